// File: rtl/mc_main_ctl.sv
// Multicycle main control FSM for the MIPS core: sequences PC, IR, ALU and the
// shared memory port, with a mem_ready stall and a watchdog on hung accesses.
module mc_main_ctl #(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       irwrite,
  output logic [1:0] pcsource,
  output logic [1:0] aluop,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       regwrite,
  output logic       regdst,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       pcwrite_c, pcwritecond_c, iord_c, memread_c, memwrite_c;
  logic       memtoreg_c, irwrite_c, alusrca_c, regwrite_c, regdst_c;
  logic [1:0] pcsource_c, aluop_c, alusrcb_c;
  logic       illegal_c, timeout_c, mem_state, limit_hit;

  always_comb begin
    pcwrite_c     = 1'b0;
    pcwritecond_c = 1'b0;
    iord_c        = 1'b0;
    memread_c     = 1'b0;
    memwrite_c    = 1'b0;
    memtoreg_c    = 1'b0;
    irwrite_c     = 1'b0;
    alusrca_c     = 1'b0;
    regwrite_c    = 1'b0;
    regdst_c      = 1'b0;
    pcsource_c    = 2'b00;
    aluop_c       = 2'b00;
    alusrcb_c     = 2'b00;
    illegal_c     = 1'b0;
    timeout_c     = 1'b0;
    state_d       = S_FETCH;

    mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    limit_hit = mem_state && !mem_ready && (cnt_q == LIMIT_M1);

    case (state_q)
      S_FETCH: begin
        memread_c = 1'b1;
        alusrcb_c = 2'b01;
        irwrite_c = mem_ready;
        pcwrite_c = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb_c = 2'b11;
        case (opcode)
          6'd0:         state_d = S_EXEC;
          6'd35, 6'd43: state_d = S_MEMADR;
          6'd4:         state_d = S_BRANCH;
          6'd2:         state_d = S_JUMP;
          6'd8:         state_d = S_ADDIEX;
          default:      illegal_c = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        if (state_q == S_ADDIEX) state_d = S_ADDIWB;
        else                     state_d = (opcode == 6'd43) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memread_c = 1'b1;
        iord_c    = 1'b1;
        state_d   = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWR: begin
        memwrite_c = 1'b1;
        iord_c     = 1'b1;
        state_d    = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg_c = 1'b1;
      end
      S_EXEC: begin
        alusrca_c = 1'b1;
        aluop_c   = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_c = 1'b1;
        regdst_c   = 1'b1;
      end
      S_ADDIWB: regwrite_c = 1'b1;
      S_BRANCH: begin
        alusrca_c     = 1'b1;
        aluop_c       = 2'b01;
        pcwritecond_c = 1'b1;
        pcsource_c    = 2'b01;
      end
      S_JUMP: begin
        pcwrite_c  = 1'b1;
        pcsource_c = 2'b10;
      end
      default: ;
    endcase

    // A hung access abandons the current step and restarts at FETCH.
    if (limit_hit) begin
      timeout_c = 1'b1;
      state_d   = S_FETCH;
    end

    if (!mem_state || mem_ready || limit_hit || (state_d != state_q)) cnt_d = '0;
    else                                                              cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Every output, including the debug state, reads 0 while reset is held.
  assign pcwrite     = pcwrite_c     & ~reset;
  assign pcwritecond = pcwritecond_c & ~reset;
  assign iord        = iord_c        & ~reset;
  assign memread     = memread_c     & ~reset;
  assign memwrite    = memwrite_c    & ~reset;
  assign memtoreg    = memtoreg_c    & ~reset;
  assign irwrite     = irwrite_c     & ~reset;
  assign alusrca     = alusrca_c     & ~reset;
  assign regwrite    = regwrite_c    & ~reset;
  assign regdst      = regdst_c      & ~reset;
  assign pcsource    = reset ? 2'b00 : pcsource_c;
  assign aluop       = reset ? 2'b00 : aluop_c;
  assign alusrcb     = reset ? 2'b00 : alusrcb_c;
  assign state       = reset ? 4'd0  : state_q;
  assign illegal_op  = illegal_c     & ~reset;
  assign mem_timeout = timeout_c     & ~reset;

endmodule

// File: tb/tb_mc_main_ctl.sv
// Directed bench for mc_main_ctl: a per-cycle reference model of the control
// sequence plus literal spot checks on the instruction traces.
module tb_mc_main_ctl;
  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b1;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite;
  logic [1:0] pcsource, aluop, alusrcb;
  logic       alusrca, regwrite, regdst, illegal_op, mem_timeout;
  logic [3:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  mc_main_ctl #(.WAIT_LIMIT(LIMIT), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
    .irwrite(irwrite), .pcsource(pcsource), .aluop(aluop),
    .alusrca(alusrca), .alusrcb(alusrcb), .regwrite(regwrite),
    .regdst(regdst), .state(state), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the instruction step the core is in and how long the
  // current memory access has been waiting.
  int m_state = 0;
  int m_wait  = 0;

  always @(negedge clk) begin
    logic       e_pcw, e_pcwc, e_iord, e_mrd, e_mwr, e_mtr, e_irw, e_asa, e_rw, e_rd, e_ill, e_to;
    logic [1:0] e_pcs, e_aop, e_asb;
    logic [3:0] e_st;
    logic       waiting, legal;
    int         nxt;
    {e_pcw, e_pcwc, e_iord, e_mrd, e_mwr, e_mtr, e_irw, e_asa, e_rw, e_rd, e_ill, e_to} = '0;
    {e_pcs, e_aop, e_asb} = '0;
    e_st = 4'd0;
    nxt  = 0;
    if (!reset) begin
      e_st    = 4'(m_state);
      e_mrd   = (m_state == 0) || (m_state == 3);
      e_mwr   = (m_state == 5);
      e_iord  = (m_state == 3) || (m_state == 5);
      e_irw   = (m_state == 0) && mem_ready;
      e_pcw   = ((m_state == 0) && mem_ready) || (m_state == 9);
      e_pcwc  = (m_state == 8);
      e_rw    = (m_state == 4) || (m_state == 7) || (m_state == 11);
      e_rd    = (m_state == 7);
      e_mtr   = (m_state == 4);
      e_asa   = (m_state == 2) || (m_state == 10) || (m_state == 6) || (m_state == 8);
      e_pcs   = (m_state == 8) ? 2'b01 : (m_state == 9) ? 2'b10 : 2'b00;
      e_aop   = (m_state == 6) ? 2'b10 : (m_state == 8) ? 2'b01 : 2'b00;
      e_asb   = (m_state == 0) ? 2'b01 : (m_state == 1) ? 2'b11 :
                ((m_state == 2) || (m_state == 10)) ? 2'b10 : 2'b00;
      legal   = (opcode == 0) || (opcode == 35) || (opcode == 43) ||
                (opcode == 4) || (opcode == 2) || (opcode == 8);
      e_ill   = (m_state == 1) && !legal;
      waiting = ((m_state == 0) || (m_state == 3) || (m_state == 5)) && !mem_ready;
      e_to    = waiting && (m_wait + 1 == LIMIT);
      case (m_state)
        0: nxt = mem_ready ? 1 : 0;
        1: nxt = (opcode == 0) ? 6 : (opcode == 35 || opcode == 43) ? 2 :
                 (opcode == 4) ? 8 : (opcode == 2) ? 9 : (opcode == 8) ? 10 : 0;
        2: nxt = (opcode == 43) ? 5 : 3;
        3: nxt = mem_ready ? 4 : 3;
        5: nxt = mem_ready ? 0 : 5;
        6: nxt = 7;
        10: nxt = 11;
        default: nxt = 0;
      endcase
      if (e_to) nxt = 0;
    end
    chk("m_pcwrite", {3'b0, pcwrite}, {3'b0, e_pcw});
    chk("m_pcwritecond", {3'b0, pcwritecond}, {3'b0, e_pcwc});
    chk("m_iord", {3'b0, iord}, {3'b0, e_iord});
    chk("m_memread", {3'b0, memread}, {3'b0, e_mrd});
    chk("m_memwrite", {3'b0, memwrite}, {3'b0, e_mwr});
    chk("m_memtoreg", {3'b0, memtoreg}, {3'b0, e_mtr});
    chk("m_irwrite", {3'b0, irwrite}, {3'b0, e_irw});
    chk("m_alusrca", {3'b0, alusrca}, {3'b0, e_asa});
    chk("m_regwrite", {3'b0, regwrite}, {3'b0, e_rw});
    chk("m_regdst", {3'b0, regdst}, {3'b0, e_rd});
    chk("m_pcsource", {2'b0, pcsource}, {2'b0, e_pcs});
    chk("m_aluop", {2'b0, aluop}, {2'b0, e_aop});
    chk("m_alusrcb", {2'b0, alusrcb}, {2'b0, e_asb});
    chk("m_state", state, e_st);
    chk("m_illegal_op", {3'b0, illegal_op}, {3'b0, e_ill});
    chk("m_mem_timeout", {3'b0, mem_timeout}, {3'b0, e_to});
    if (reset) begin
      m_state = 0;
      m_wait  = 0;
    end else begin
      m_wait  = (waiting && !e_to) ? m_wait + 1 : 0;
      m_state = nxt;
    end
  end

  task automatic step(input logic rst, input logic rdy, input logic [5:0] op,
                      input logic [3:0] exp_st);
    @(posedge clk);
    #1;
    reset     = rst;
    mem_ready = rdy;
    opcode    = op;
    @(negedge clk);
    chk("trace_state", state, exp_st);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // reset held three cycles
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 6'd0, 4'd0);
      chk("rst_memread", {3'b0, memread}, 4'd0);
    end
    step(1'b0, 1'b1, 6'd0, 4'd0);
    chk("post_rst_memread", {3'b0, memread}, 4'd1);
    chk("post_rst_alusrcb", {2'b0, alusrcb}, 4'd1);
    chk("post_rst_irwrite", {3'b0, irwrite}, 4'd1);
    chk("post_rst_pcwrite", {3'b0, pcwrite}, 4'd1);
    // R-type
    step(1'b0, 1'b1, 6'd0, 4'd1);
    step(1'b0, 1'b1, 6'd0, 4'd6);
    chk("r_aluop", {2'b0, aluop}, 4'd2);
    step(1'b0, 1'b1, 6'd0, 4'd7);
    chk("r_regwrite", {3'b0, regwrite}, 4'd1);
    chk("r_regdst", {3'b0, regdst}, 4'd1);
    // lw with two wait cycles in MEMRD
    step(1'b0, 1'b1, 6'd35, 4'd0);
    step(1'b0, 1'b1, 6'd35, 4'd1);
    step(1'b0, 1'b1, 6'd35, 4'd2);
    step(1'b0, 1'b0, 6'd35, 4'd3);
    chk("lw_iord", {3'b0, iord}, 4'd1);
    step(1'b0, 1'b0, 6'd35, 4'd3);
    step(1'b0, 1'b1, 6'd35, 4'd3);
    step(1'b0, 1'b1, 6'd35, 4'd4);
    chk("lw_memtoreg", {3'b0, memtoreg}, 4'd1);
    // sw, beq, j
    step(1'b0, 1'b1, 6'd43, 4'd0);
    step(1'b0, 1'b1, 6'd43, 4'd1);
    step(1'b0, 1'b1, 6'd43, 4'd2);
    step(1'b0, 1'b1, 6'd43, 4'd5);
    chk("sw_memwrite", {3'b0, memwrite}, 4'd1);
    step(1'b0, 1'b1, 6'd4, 4'd0);
    step(1'b0, 1'b1, 6'd4, 4'd1);
    step(1'b0, 1'b1, 6'd4, 4'd8);
    chk("beq_aluop", {2'b0, aluop}, 4'd1);
    chk("beq_pcwritecond", {3'b0, pcwritecond}, 4'd1);
    chk("beq_pcsource", {2'b0, pcsource}, 4'd1);
    step(1'b0, 1'b1, 6'd2, 4'd0);
    step(1'b0, 1'b1, 6'd2, 4'd1);
    step(1'b0, 1'b1, 6'd2, 4'd9);
    chk("j_pcwrite", {3'b0, pcwrite}, 4'd1);
    chk("j_pcsource", {2'b0, pcsource}, 4'd2);
    // illegal opcode, then a FETCH that hangs until the watchdog fires
    step(1'b0, 1'b1, 6'd63, 4'd0);
    step(1'b0, 1'b1, 6'd63, 4'd1);
    chk("ill_pulse", {3'b0, illegal_op}, 4'd1);
    step(1'b0, 1'b0, 6'd63, 4'd0);
    chk("ill_once", {3'b0, illegal_op}, 4'd0);
    step(1'b0, 1'b0, 6'd63, 4'd0);
    step(1'b0, 1'b0, 6'd63, 4'd0);
    step(1'b0, 1'b0, 6'd63, 4'd0);
    chk("fetch_timeout", {3'b0, mem_timeout}, 4'd1);
    chk("fetch_to_irwrite", {3'b0, irwrite}, 4'd0);
    step(1'b0, 1'b1, 6'd43, 4'd0);
    chk("fetch_after_to", {3'b0, mem_timeout}, 4'd0);
    // sw stuck in MEMWR times out
    step(1'b0, 1'b1, 6'd43, 4'd1);
    step(1'b0, 1'b1, 6'd43, 4'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 6'd43, 4'd5);
    step(1'b0, 1'b0, 6'd43, 4'd5);
    chk("sw_timeout", {3'b0, mem_timeout}, 4'd1);
    step(1'b0, 1'b1, 6'd43, 4'd0);
    chk("sw_to_memwrite_drop", {3'b0, memwrite}, 4'd0);
    // sw with ready arriving in the limit cycle
    step(1'b0, 1'b1, 6'd43, 4'd1);
    step(1'b0, 1'b1, 6'd43, 4'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 6'd43, 4'd5);
    step(1'b0, 1'b1, 6'd43, 4'd5);
    chk("sw_limit_ready", {3'b0, mem_timeout}, 4'd0);
    step(1'b0, 1'b1, 6'd8, 4'd0);
    // addi
    step(1'b0, 1'b1, 6'd8, 4'd1);
    step(1'b0, 1'b1, 6'd8, 4'd10);
    step(1'b0, 1'b1, 6'd8, 4'd11);
    chk("addi_regwrite", {3'b0, regwrite}, 4'd1);
    chk("addi_regdst", {3'b0, regdst}, 4'd0);
    // reset mid-instruction
    step(1'b0, 1'b1, 6'd0, 4'd0);
    step(1'b0, 1'b1, 6'd0, 4'd1);
    step(1'b0, 1'b1, 6'd0, 4'd6);
    step(1'b1, 1'b1, 6'd0, 4'd0);
    chk("mid_rst_aluop", {2'b0, aluop}, 4'd0);
    step(1'b0, 1'b1, 6'd0, 4'd0);
    chk("mid_rst_memread", {3'b0, memread}, 4'd1);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
